// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// One multiplier or quotient bit per cycle for 32 cycles, then one sign-fixup cycle.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  AluControl,
   input  logic [31:0] OpA,
   input  logic [31:0] OpB,
   input  logic        MtHi,
   input  logic        MtLo,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, state_nx;
   logic [4:0]  count;
   logic        op_div;
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b;
   logic [31:0] quo;          // dividend/quotient for divide, multiplier/low product for multiply
   logic [32:0] rem;          // partial remainder for divide, high product (+carry) for multiply

   // Start decode: codes 1000..1011; bit1 selects multiply, bit0 selects unsigned.
   logic        accept;
   logic        req_signed;
   logic [31:0] abs_a, abs_b;

   assign accept     = (state == IDLE) && Start && (AluControl[3:2] == 2'b10);
   assign req_signed = ~AluControl[0];
   // 0 - 0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude.
   assign abs_a      = (req_signed && OpA[31]) ? (32'd0 - OpA) : OpA;
   assign abs_b      = (req_signed && OpB[31]) ? (32'd0 - OpB) : OpB;

   // One iteration step of each algorithm.
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [33:0] div_trial;
   logic        div_ge;

   assign mul_sum   = rem + (quo[0] ? {1'b0, mag_a} : 33'd0);
   assign div_shift = {rem[31:0], quo[31]};
   assign div_trial = {1'b0, div_shift} - {2'b00, mag_b};
   assign div_ge    = ~div_trial[33];

   // Sign fixup applied in FIX.
   logic [63:0] product, product_fix;
   logic [31:0] quo_fix, rem_fix;
   logic        div_by_zero;

   assign product     = {rem[31:0], quo};
   assign product_fix = (neg_a ^ neg_b) ? (64'd0 - product) : product;
   assign quo_fix     = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
   assign rem_fix     = neg_a ? (32'd0 - rem[31:0]) : rem[31:0];
   assign div_by_zero = (mag_b == 32'd0);

   assign Busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_nx unassigned (no latch).
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = CALC;
         CALC:    if (count == 5'd31) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture and per-cycle shift-add / restoring-divide iteration.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= 5'd0;
         op_div <= 1'b0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         mag_a  <= 32'd0;
         mag_b  <= 32'd0;
         quo    <= 32'd0;
         rem    <= 33'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_div <= ~AluControl[1];
                  neg_a  <= req_signed & OpA[31];
                  neg_b  <= req_signed & OpB[31];
                  mag_a  <= abs_a;
                  mag_b  <= abs_b;
                  quo    <= AluControl[1] ? abs_b : abs_a;
                  rem    <= 33'd0;
                  count  <= 5'd0;
               end
            end
            CALC: begin
               count <= count + 5'd1;
               if (op_div) begin
                  rem <= div_ge ? div_trial[32:0] : div_shift;
                  quo <= {quo[30:0], div_ge};
               end else begin
                  rem <= {1'b0, mul_sum[32:1]};
                  quo <= {mul_sum[0], quo[31:1]};
               end
            end
            default: ;
         endcase
      end
   end

   // Architectural HI/LO: result write in FIX, MTHI/MTLO only when idle and no Start is taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Hi <= 32'd0;
         Lo <= 32'd0;
      end else if (state == FIX) begin
         if (!op_div) begin
            Hi <= product_fix[63:32];
            Lo <= product_fix[31:0];
         end else if (div_by_zero) begin
            // Remainder register holds |OpA|; negating by neg_a restores the original OpA.
            Hi <= rem_fix;
            Lo <= 32'hFFFF_FFFF;
         end else begin
            Hi <= rem_fix;
            Lo <= quo_fix;
         end
      end else if (state == IDLE && !accept) begin
         if (MtHi) Hi <= OpA;
         if (MtLo) Lo <= OpA;
      end
   end

   // Done pulses for the single cycle after FIX.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) Done <= 1'b0;
      else        Done <= (state == FIX);
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide engine that executes the HI/LO-class codes produced by the ALU control decoder (AluControl 1000 DIV, 1001 DIVU, 1010 MULT, 1011 MULTU). It sits beside the combinational ALU in the execute stage and owns the architectural HI and LO registers. The FSM stalls on `Busy` and reads results once `Done` pulses. MTHI/MTLO writes also land here.

## Interface
Parameters: none (datapath fixed at 32 bits, iteration count fixed at 32).
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  request to begin the operation selected by `AluControl`
- `AluControl`  in  4  operation code; only 1000/1001/1010/1011 are accepted
- `OpA`  in  32  rs value (dividend / multiplicand / MTHI-MTLO data)
- `OpB`  in  32  rt value (divisor / multiplier)
- `MtHi`  in  1  write `OpA` into Hi
- `MtLo`  in  1  write `OpA` into Lo
- `Busy`  out  1  operation in progress
- `Done`  out  1  one-cycle pulse; Hi/Lo hold new result in this cycle
- `Hi`  out  32  HI register
- `Lo`  out  32  LO register

## Operation
- States: IDLE, CALC, FIX. Reset (`reset`=0, async): state IDLE, iteration counter 0, `Busy`=0, `Done`=0, `Hi`=0, `Lo`=0, internal operand and accumulator registers cleared.
- IDLE: if `Start`=1 and `AluControl` is in 1000..1011, latch op, operand magnitudes and sign flags, and go to CALC with counter 0. `Start` with any other code is ignored.
- Signed ops (DIV, MULT): operands are converted to magnitude. |0x80000000| = 0x80000000 as unsigned. Record negA and negB. Unsigned ops use operands as-is, with both flags 0.
- MULT/MULTU in CALC: shift-add, one multiplier bit per cycle (LSB first) into a 64-bit accumulator.
- DIV/DIVU in CALC: restoring division, one quotient bit per cycle (MSB first). Remainder is 33-bit internal.
- Counter 31 in CALC moves the state to FIX.
- FIX, multiply: if negA^negB, product := two's-complement negation (64-bit). Hi := product[63:32], Lo := product[31:0].
- FIX, divide, divisor nonzero:
  - quotient negated if negA^negB; remainder negated if negA.
  - Lo := quotient, Hi := remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives Lo=0x80000000, Hi=0; this is the natural wrap and needs no special case.
- FIX, divide by zero (OpB=0, DIV or DIVU): Lo := 0xFFFFFFFF, Hi := original OpA. Latency is unchanged.
- FIX always returns to IDLE and sets `Done`=1 for the next cycle.
- MTHI/MTLO: in IDLE with no accepted `Start`, `MtHi`=1 writes `Hi` := `OpA` at the next edge; `MtLo` likewise writes `Lo`. Both may be set together. Ignored while `Busy`. Ignored when `Start` is accepted in the same cycle (Start has priority).
- `Hi`/`Lo` are never modified by CALC; they change only in FIX, on an MT write, or on reset.

## Timing
- Start accepted at edge E0.
- `Busy`=1 from just after E0 until edge E33: 32 CALC cycles (E1..E32 perform iterations) plus 1 FIX cycle.
- `Hi`/`Lo` update at E33. `Done`=1 and `Busy`=0 for the cycle E33..E34. Start-to-Done latency is 33 cycles.
- `Done` is registered, high for exactly one cycle, and never high while `Busy`=1.
- A `Start` during the `Done` cycle is accepted (state is IDLE), so operations can run back-to-back with no gap.
- `Start` while `Busy` is ignored. It is not queued and does not disturb the in-flight operation.
- Operands are sampled only at E0. `OpA`/`OpB`/`AluControl` may change freely afterwards.
- Reset mid-operation aborts immediately (asynchronously) to reset values. No partial result reaches Hi/Lo.

## Test plan
- MULT OpA=0xFFFFFFFF, OpB=0x00000002 -> at Done: Hi=0xFFFFFFFF, Lo=0xFFFFFFFE. MULTU with the same operands -> Hi=0x00000001, Lo=0xFFFFFFFE. Done exactly 34 edges after Start is sampled, measured from E0 to the end of the Done cycle.
- DIV OpA=0xFFFFFFF9 (-7), OpB=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7/2 -> Lo=3, Hi=1. MULT 0x80000000 * 0x80000000 -> Hi=0x40000000, Lo=0.
- Boundaries:
  - DIVU 5/0 -> Lo=0xFFFFFFFF, Hi=5.
  - DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
  - Start with AluControl=0010 -> Busy stays 0, Hi/Lo unchanged.
- Handshake:
  - Start a MULTU 3*4, re-assert Start with DIVU 9/3 at cycle 10 -> ignored, result Hi=0, Lo=12.
  - Assert Start (DIVU 9/3) during the Done cycle -> accepted; Lo=3, Hi=0 after 33 more cycles.
- MT writes:
  - MtHi=1, OpA=0x12345678 in IDLE -> Hi=0x12345678 next cycle.
  - MtLo during Busy -> Lo unchanged.
  - MtHi together with an accepted Start -> Hi reflects only the operation result.
- Drop reset to 0 at CALC iteration 10 -> Busy=0, Done=0, Hi=Lo=0 without waiting for a clock. After release, MULTU 6*7 gives Lo=42, Hi=0 with normal latency.
